// File: rtl/regfile_loader_if.sv
// regfile_loader_if: bundles the signals between a loader and its environment.
//   start/start_addr/word_count : load command (sampled on start)
//   in_valid/in_data/in_ready   : byte stream handshake
//   wr_enable/wr_address/wr_data: register file write port
//   busy/done                   : load status
// The slave modport is the loader's view; the master modport is the driver's view.
interface regfile_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYTE_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, word_count, in_valid, in_data,
    input  in_ready, wr_enable, wr_address, wr_data, busy, done
  );

  modport slave (
    input  start, start_addr, word_count, in_valid, in_data,
    output in_ready, wr_enable, wr_address, wr_data, busy, done
  );
endinterface

// File: rtl/regfile_loader.sv
// regfile_loader: assembles a little-endian byte stream into DATA_W-bit words
// and writes them into the register file at consecutive addresses (wrapping
// modulo 2^ADDR_W) starting at a programmed base.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, aborts any load in progress
//   bus   : regfile_loader_if.slave (command, byte stream, write port, status)
// All outputs come straight from flops.
module regfile_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYTE_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  regfile_loader_if.slave bus
);
  localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  byte_cnt_r, byte_cnt_nxt_s;
  logic [ADDR_W:0]   words_left_r, words_left_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [DATA_W-1:0] asm_r, asm_nxt_s;
  logic              in_ready_r, in_ready_nxt_s;
  logic              wr_enable_r, wr_enable_nxt_s;
  logic [ADDR_W-1:0] wr_address_r, wr_address_nxt_s;
  logic [DATA_W-1:0] wr_data_r, wr_data_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              xfer_s;

  // in_ready_r already reflects COLLECT, so this is exactly the accepted-byte condition
  assign xfer_s = bus.in_valid & in_ready_r;

  // Next-state, datapath and next-output computation
  always_comb begin
    state_nxt_s      = state_r;
    byte_cnt_nxt_s   = byte_cnt_r;
    words_left_nxt_s = words_left_r;
    addr_nxt_s       = addr_r;
    asm_nxt_s        = asm_r;
    wr_address_nxt_s = wr_address_r;
    wr_data_nxt_s    = wr_data_r;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.word_count != {(ADDR_W+1){1'b0}}) begin
            addr_nxt_s       = bus.start_addr;
            words_left_nxt_s = bus.word_count;
            byte_cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s      = COLLECT;
          end else begin
            state_nxt_s      = FINISH;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (xfer_s) begin
          asm_nxt_s[int'(byte_cnt_r)*BYTE_W +: BYTE_W] = bus.in_data;
          if (byte_cnt_r == CNT_W'(BYTES_PER_WORD - 1)) begin
            // Word complete: the write cycle presents the freshly merged word
            byte_cnt_nxt_s   = {CNT_W{1'b0}};
            wr_address_nxt_s = addr_r;
            wr_data_nxt_s    = asm_nxt_s;
            state_nxt_s      = WRITE;
          end else begin
            byte_cnt_nxt_s   = byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      WRITE: begin
        // Address wraps naturally at ADDR_W bits
        addr_nxt_s       = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        words_left_nxt_s = words_left_r - {{ADDR_W{1'b0}}, 1'b1};
        if (words_left_r == {{ADDR_W{1'b0}}, 1'b1}) begin
          state_nxt_s = FINISH;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the flops present them in-state
    in_ready_nxt_s  = (state_nxt_s == COLLECT);
    wr_enable_nxt_s = (state_nxt_s == WRITE);
    busy_nxt_s      = (state_nxt_s != IDLE);
    done_nxt_s      = (state_nxt_s == FINISH);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_r   <= {CNT_W{1'b0}};
      words_left_r <= {(ADDR_W+1){1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      asm_r        <= {DATA_W{1'b0}};
      in_ready_r   <= 1'b0;
      wr_enable_r  <= 1'b0;
      wr_address_r <= {ADDR_W{1'b0}};
      wr_data_r    <= {DATA_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      byte_cnt_r   <= byte_cnt_nxt_s;
      words_left_r <= words_left_nxt_s;
      addr_r       <= addr_nxt_s;
      asm_r        <= asm_nxt_s;
      in_ready_r   <= in_ready_nxt_s;
      wr_enable_r  <= wr_enable_nxt_s;
      wr_address_r <= wr_address_nxt_s;
      wr_data_r    <= wr_data_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.wr_enable  = wr_enable_r;
  assign bus.wr_address = wr_address_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_regfile_loader.sv
// Testbench for regfile_loader: directed scenarios plus randomized loads
// checked against a word/address model built from the byte stream.
module tb_regfile_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_loader_if #(.DATA_W(32), .ADDR_W(5), .BYTE_W(8)) bus ();

  regfile_loader #(.DATA_W(32), .ADDR_W(5), .BYTE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        rdy;
    int          cyc;
  } wr_t;

  wr_t obs[$];
  wr_t mon_w;
  int  cyc = 0;
  int  done_cnt = 0;
  int  last_done_cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;

  // Monitor: record every write strobe and done pulse, sampled mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.wr_enable === 1'b1) begin
      mon_w.a   = bus.wr_address;
      mon_w.d   = bus.wr_data;
      mon_w.rdy = bus.in_ready;
      mon_w.cyc = cyc;
      obs.push_back(mon_w);
    end
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      last_done_cyc = cyc;
    end
  end

  // Reference: word w is bytes 4w..4w+3 with the first byte least significant
  function automatic logic [31:0] model_word(input byte_q_t b, input int w);
    logic [31:0] r = 32'd0;
    for (int k = 0; k < 4; k++) r = r + (32'(b[4*w+k]) << (8*k));
    return r;
  endfunction

  function automatic byte_q_t rand_bytes(input int nwords);
    byte_q_t q;
    for (int i = 0; i < 4*nwords; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic clear_mon();
    obs.delete();
    done_cnt = 0;
  endtask

  // Called at a negedge; pulses start for one cycle
  task automatic do_start(input logic [4:0] a, input logic [5:0] n);
    bus.start = 1'b1; bus.start_addr = a; bus.word_count = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random stalls
  task automatic send_bytes(input byte_q_t b, input int mode);
    bit hs;
    foreach (b[i]) begin
      if (mode == 1 && i > 0) begin
        bus.in_valid = 1'b0; @(negedge clk);
      end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0; repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b1; bus.in_data = b[i];
      hs = 1'b0;
      for (int g = 0; g < 50 && !hs; g++) begin
        hs = bus.in_ready;
        @(negedge clk);
      end
      if (!hs) begin
        n_cmp++; n_fail++;
        $display("FAIL handshake_timeout byte %0d: in_ready=0 for 50 cycles, required 1", i);
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin seen = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.start_addr = 5'd0; bus.word_count = 6'd0;
    bus.in_valid = 1'b0; bus.in_data = 8'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.wr_enable, bus.wr_address, bus.wr_data, bus.busy, bus.done} !== 41'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required 0",
        {bus.in_ready, bus.wr_enable, bus.wr_address, bus.wr_data, bus.busy, bus.done});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.wr_enable, bus.busy, bus.done} !== 4'd0) begin
      n_fail++; $display("FAIL idle_outputs: got %b, required 0000",
        {bus.in_ready, bus.wr_enable, bus.busy, bus.done});
    end
  endtask

  task automatic test_basic();
    byte_q_t q;
    bit seen;
    clear_mon();
    q = '{8'h09, 8'h00, 8'h00, 8'h00};
    do_start(5'd3, 6'd1);
    send_bytes(q, 0);
    wait_done(seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL basic_done: done=0, required a pulse"); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done: got %b, required 1", bus.busy); end
    @(negedge clk);
    n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done: busy,done=%b, required 00", {bus.busy, bus.done}); end
    n_cmp++;
    if (obs.size() != 1) begin n_fail++; $display("FAIL basic_write_count: got %0d, required 1", obs.size()); end
    else begin
      n_cmp++; if (obs[0].a !== 5'd3) begin n_fail++; $display("FAIL basic_addr: got %0d, required 3", obs[0].a); end
      n_cmp++; if (obs[0].d !== 32'h00000009) begin n_fail++; $display("FAIL basic_data: got %h, required 00000009", obs[0].d); end
      n_cmp++; if (last_done_cyc != obs[0].cyc + 1) begin n_fail++; $display("FAIL basic_done_timing: done cycle %0d, required %0d", last_done_cyc, obs[0].cyc + 1); end
    end
  endtask

  task automatic test_wrap();
    byte_q_t q;
    bit seen;
    logic [4:0]  ea [3] = '{5'd30, 5'd31, 5'd0};
    logic [31:0] ed [3] = '{32'h14131211, 32'h18171615, 32'h1C1B1A19};
    clear_mon();
    for (int i = 0; i < 12; i++) q.push_back(8'(8'h11 + i));
    do_start(5'd30, 6'd3);
    send_bytes(q, 0);
    wait_done(seen);
    @(negedge clk);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL wrap_done: done=0, required a pulse"); end
    n_cmp++;
    if (obs.size() != 3) begin n_fail++; $display("FAIL wrap_write_count: got %0d, required 3", obs.size()); end
    else begin
      for (int w = 0; w < 3; w++) begin
        n_cmp++;
        if (obs[w].a !== ea[w] || obs[w].d !== ed[w]) begin
          n_fail++; $display("FAIL wrap_write%0d: got %0d/%h, required %0d/%h", w, obs[w].a, obs[w].d, ea[w], ed[w]);
        end
      end
      // Back-to-back stream: 4 transfer cycles plus 1 write cycle per word
      n_cmp++; if (obs[2].cyc - obs[0].cyc != 10) begin n_fail++; $display("FAIL wrap_spacing: got %0d cycles, required 10", obs[2].cyc - obs[0].cyc); end
    end
  endtask

  task automatic test_stalls();
    byte_q_t q;
    bit seen;
    clear_mon();
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_start(5'd12, 6'd1);
    send_bytes(q, 1);
    wait_done(seen);
    @(negedge clk);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL stall_done: done=0, required a pulse"); end
    n_cmp++;
    if (obs.size() != 1) begin n_fail++; $display("FAIL stall_write_count: got %0d, required 1", obs.size()); end
    else begin
      n_cmp++; if (obs[0].a !== 5'd12 || obs[0].d !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL stall_write: got %0d/%h, required 12/ddccbbaa", obs[0].a, obs[0].d); end
      n_cmp++; if (obs[0].rdy !== 1'b0) begin n_fail++; $display("FAIL stall_ready_in_write: got %b, required 0", obs[0].rdy); end
    end
  endtask

  task automatic test_zero_and_ignored();
    byte_q_t q;
    bit seen;
    clear_mon();
    do_start(5'd5, 6'd0);
    n_cmp++; if ({bus.done, bus.busy} !== 2'b11) begin n_fail++; $display("FAIL zero_done: done,busy=%b, required 11", {bus.done, bus.busy}); end
    @(negedge clk);
    n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL zero_end: done,busy=%b, required 00", {bus.done, bus.busy}); end
    n_cmp++; if (obs.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d, required 0", obs.size()); end
    clear_mon();
    q = rand_bytes(2);
    do_start(5'd10, 6'd2);
    do_start(5'd7, 6'd5);
    send_bytes(q, 0);
    wait_done(seen);
    @(negedge clk);
    n_cmp++;
    if (obs.size() != 2) begin n_fail++; $display("FAIL ignore_write_count: got %0d, required 2", obs.size()); end
    else begin
      for (int w = 0; w < 2; w++) begin
        n_cmp++;
        if (obs[w].a !== 5'(10 + w) || obs[w].d !== model_word(q, w)) begin
          n_fail++; $display("FAIL ignore_write%0d: got %0d/%h, required %0d/%h", w, obs[w].a, obs[w].d, 10 + w, model_word(q, w));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t q;
    byte_q_t part;
    bit seen;
    clear_mon();
    q = rand_bytes(1);
    part = q[0:1];
    do_start(5'd20, 6'd1);
    send_bytes(part, 0);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, required 1", bus.busy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.wr_enable, bus.wr_address, bus.wr_data, bus.busy, bus.done} !== 41'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h, required 0",
        {bus.in_ready, bus.wr_enable, bus.wr_address, bus.wr_data, bus.busy, bus.done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++; if (obs.size() != 0 || done_cnt != 0) begin n_fail++; $display("FAIL midrst_aborted: writes %0d done %0d, required 0 0", obs.size(), done_cnt); end
    q = rand_bytes(1);
    do_start(5'd20, 6'd1);
    send_bytes(q, 0);
    wait_done(seen);
    @(negedge clk);
    n_cmp++;
    if (obs.size() != 1 || obs[0].a !== 5'd20 || obs[0].d !== model_word(q, 0)) begin
      n_fail++; $display("FAIL midrst_reload: writes %0d first %0d/%h, required 1 write 20/%h",
        obs.size(), (obs.size() > 0) ? obs[0].a : 5'd0, (obs.size() > 0) ? obs[0].d : 32'd0, model_word(q, 0));
    end
  endtask

  task automatic test_random();
    byte_q_t q;
    bit seen;
    int a, n;
    for (int t = 0; t < 6; t++) begin
      clear_mon();
      a = $urandom_range(0, 31);
      n = (t == 5) ? 32 : $urandom_range(1, 5);
      q = rand_bytes(n);
      do_start(5'(a), 6'(n));
      send_bytes(q, 2);
      wait_done(seen);
      @(negedge clk);
      n_cmp++; if (!seen || done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: pulses %0d, required 1", t, done_cnt); end
      n_cmp++;
      if (obs.size() != n) begin n_fail++; $display("FAIL rand%0d_write_count: got %0d, required %0d", t, obs.size(), n); end
      else begin
        for (int w = 0; w < n; w++) begin
          n_cmp++;
          if (obs[w].a !== 5'((a + w) % 32) || obs[w].d !== model_word(q, w)) begin
            n_fail++; $display("FAIL rand%0d_write%0d: got %0d/%h, required %0d/%h", t, w, obs[w].a, obs[w].d, (a + w) % 32, model_word(q, w));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stalls();
    test_zero_and_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
